// File: rtl/not_gate_reg.sv
// Bit-wise inverter with a registered inverse, per-bit edge pulses and a
// saturating transition counter. The combinational path y = ~a needs no clock.
module not_gate_reg #(
  parameter int WIDTH   = 1,
  parameter int COUNT_W = 8
) (
  input  logic [WIDTH-1:0]   a,
  output logic [WIDTH-1:0]   y,
  input  logic               clk,
  input  logic               rst,
  output logic [WIDTH-1:0]   y_q,
  output logic [WIDTH-1:0]   rise,
  output logic [WIDTH-1:0]   fall,
  output logic [COUNT_W-1:0] tcount,
  input  logic               clr
);

  logic [WIDTH-1:0]   a_d;
  logic [WIDTH-1:0]   a_prev_q;
  logic [WIDTH-1:0]   y_q_q;
  logic [WIDTH-1:0]   rise_q;
  logic [WIDTH-1:0]   fall_q;
  logic [WIDTH-1:0]   rise_d;
  logic [WIDTH-1:0]   fall_d;
  logic [COUNT_W-1:0] tcount_q;
  logic [COUNT_W-1:0] tcount_d;
  logic [COUNT_W:0]   tcount_inc;
  logic               changed;

  assign y = ~a;

  always_comb begin
    changed    = (a != a_d);
    rise_d     = a_d & ~a_prev_q;
    fall_d     = ~a_d & a_prev_q;
    tcount_inc = {1'b0, tcount_q} + {{COUNT_W{1'b0}}, 1'b1};
    tcount_d   = tcount_q;
    // Clear wins over an increment; the carry bit flags saturation.
    if (clr) begin
      tcount_d = '0;
    end else if (changed && !tcount_inc[COUNT_W]) begin
      tcount_d = tcount_inc[COUNT_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_d      <= '0;
      a_prev_q <= '0;
      y_q_q    <= '1;
      rise_q   <= '0;
      fall_q   <= '0;
      tcount_q <= '0;
    end else begin
      a_d      <= a;
      a_prev_q <= a_d;
      y_q_q    <= ~a;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      tcount_q <= tcount_d;
    end
  end

  assign y_q    = y_q_q;
  assign rise   = rise_q;
  assign fall   = fall_q;
  assign tcount = tcount_q;

endmodule

// File: tb/tb_not_gate_reg.sv
// Directed bench for not_gate_reg (WIDTH=4, COUNT_W=3): combinational path,
// async reset, registered inverse, edge pulses, saturation/clear, mid-run reset.
module tb_not_gate_reg;

  localparam int WIDTH   = 4;
  localparam int COUNT_W = 3;

  logic               clk = 1'b0;
  logic               clk_en = 1'b0;
  logic               rst = 1'b0;
  logic               clr = 1'b0;
  logic [WIDTH-1:0]   a = '0;
  logic [WIDTH-1:0]   y;
  logic [WIDTH-1:0]   y_q;
  logic [WIDTH-1:0]   rise;
  logic [WIDTH-1:0]   fall;
  logic [COUNT_W-1:0] tcount;
  logic               gate_phase = 1'b0;

  int checks = 0;
  int errors = 0;

  not_gate_reg #(.WIDTH(WIDTH), .COUNT_W(COUNT_W)) u_dut (
    .a(a), .y(y), .clk(clk), .rst(rst), .y_q(y_q),
    .rise(rise), .fall(fall), .tcount(tcount), .clr(clr)
  );

  always #5 clk = clk_en ? ~clk : 1'b0;

  always @(a[0] or y[0]) begin
    if (gate_phase) $display("t=%0t a=%b y=%b", $time, a[0], y[0]);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    a   = '0;
    clr = 1'b0;
    rst = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  task automatic test_gate();
    gate_phase = 1'b1;
    clk_en = 1'b1;
    a = 4'h0;
    #1;
    checks++;
    if (y !== 4'hF) begin errors++; $display("FAIL gate_low: y=%h expected %h", y, 4'hF); end
    #8;
    checks++;
    if (y !== 4'hF) begin errors++; $display("FAIL gate_low_hold: y=%h expected %h", y, 4'hF); end
    #1;
    a = 4'h1;
    #0;
    checks++;
    if (y[0] !== 1'b0) begin errors++; $display("FAIL gate_same_step: y0=%b expected 0", y[0]); end
    #5;
    checks++;
    if (y !== 4'hE) begin errors++; $display("FAIL gate_high: y=%h expected %h", y, 4'hE); end
    #5;
    gate_phase = 1'b0;
  endtask

  task automatic test_reset();
    clk_en = 1'b0;
    #20;
    a = 4'h3;
    rst = 1'b1;
    #1;
    checks++;
    if (y_q !== 4'hF) begin errors++; $display("FAIL reset_y_q: y_q=%h expected F", y_q); end
    checks++;
    if (rise !== 4'h0 || fall !== 4'h0) begin
      errors++; $display("FAIL reset_edges: rise=%h fall=%h expected 0 0", rise, fall);
    end
    checks++;
    if (tcount !== 3'd0) begin errors++; $display("FAIL reset_tcount: tcount=%0d expected 0", tcount); end
    a = 4'h6;
    #1;
    checks++;
    if (y !== 4'h9) begin errors++; $display("FAIL reset_y_tracks: y=%h expected 9", y); end
    a = 4'h0;
    #1;
    rst = 1'b0;
    clk_en = 1'b1;
    tick();
  endtask

  task automatic test_registered();
    do_reset();
    tick();
    a = 4'b1010;
    tick();
    checks++;
    if (y_q !== 4'b0101 || tcount !== 3'd1) begin
      errors++; $display("FAIL reg_first: y_q=%b tcount=%0d expected 0101 1", y_q, tcount);
    end
    a = 4'b0101;
    tick();
    checks++;
    if (y_q !== 4'b1010 || tcount !== 3'd2) begin
      errors++; $display("FAIL reg_second: y_q=%b tcount=%0d expected 1010 2", y_q, tcount);
    end
    tick();
    checks++;
    if (rise !== 4'b0101 || fall !== 4'b1010 || tcount !== 3'd2) begin
      errors++;
      $display("FAIL reg_edges: rise=%b fall=%b tcount=%0d expected 0101 1010 2", rise, fall, tcount);
    end
  endtask

  task automatic test_edges();
    logic [WIDTH-1:0] exp_rise [9];
    logic [WIDTH-1:0] exp_fall [9];
    exp_rise = '{4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    exp_fall = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0};
    do_reset();
    tick();
    tick();
    a = 4'h1;
    for (int i = 0; i < 9; i++) begin
      if (i == 5) a = 4'h0;
      tick();
      checks++;
      if (rise !== exp_rise[i] || fall !== exp_fall[i]) begin
        errors++;
        $display("FAIL edges_cycle%0d: rise=%h fall=%h expected %h %h", i, rise, fall, exp_rise[i], exp_fall[i]);
      end
      checks++;
      if ((rise & fall) !== 4'h0) begin
        errors++; $display("FAIL edges_exclusive%0d: rise&fall=%h expected 0", i, rise & fall);
      end
    end
  endtask

  task automatic test_saturation();
    logic [COUNT_W-1:0] exp_cnt;
    do_reset();
    tick();
    for (int i = 0; i < 10; i++) begin
      a = a ^ 4'h1;
      tick();
      exp_cnt = (i + 1 > 7) ? 3'd7 : 3'(i + 1);
      checks++;
      if (tcount !== exp_cnt) begin
        errors++; $display("FAIL sat_count%0d: tcount=%0d expected %0d", i, tcount, exp_cnt);
      end
    end
    clr = 1'b1;
    a = a ^ 4'h1;
    tick();
    clr = 1'b0;
    checks++;
    if (tcount !== 3'd0) begin errors++; $display("FAIL clr_priority: tcount=%0d expected 0", tcount); end
    checks++;
    if (y_q !== ~a) begin errors++; $display("FAIL clr_y_q: y_q=%h expected %h", y_q, ~a); end
    a = a ^ 4'h1;
    tick();
    checks++;
    if (tcount !== 3'd1) begin errors++; $display("FAIL clr_release: tcount=%0d expected 1", tcount); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      a = a ^ 4'h5;
      tick();
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (y_q !== 4'hF || rise !== 4'h0 || fall !== 4'h0 || tcount !== 3'd0) begin
      errors++;
      $display("FAIL mid_reset_now: y_q=%h rise=%h fall=%h tcount=%0d expected F 0 0 0", y_q, rise, fall, tcount);
    end
    for (int i = 0; i < 2; i++) begin
      a = a ^ 4'h5;
      tick();
    end
    checks++;
    if (y_q !== 4'hF || tcount !== 3'd0 || y !== ~a) begin
      errors++;
      $display("FAIL mid_reset_hold: y_q=%h tcount=%0d y=%h expected F 0 %h", y_q, tcount, y, ~a);
    end
    a = 4'hF;
    #1;
    rst = 1'b0;
    tick();
    checks++;
    if (tcount !== 3'd1 || y_q !== 4'h0) begin
      errors++; $display("FAIL mid_release: tcount=%0d y_q=%h expected 1 0", tcount, y_q);
    end
  endtask

  initial begin
    test_gate();
    test_reset();
    test_registered();
    test_edges();
    test_saturation();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/not_gate_reg.md
# not_gate_reg

Bit-wise inverter with an optional registered and monitored view of its input. The combinational path `y = ~a` is the primary function and needs no clock, so simple gate-level benches can connect `a` and `y` only. The clocked side adds four things for system use:

- a one-cycle-delayed inverted output;
- rising-edge and falling-edge pulses;
- a saturating transition counter;
- a clear control.

The block sits wherever a logic inverter is needed and its activity should be observable.

## Interface
Parameters:
- `WIDTH`, default 1: width of `a`, `y` and `y_q`.
- `COUNT_W`, default 8: width of the transition counter.

Ports (clock and reset listed first; declaration order is `a`, `y`, `clk`, `rst`, then the rest, so a positional two-port instance `(a, y)` is legal):
- `clk`  in  1  clock, rising edge; one clock domain.
- `rst`  in  1  reset, asynchronous, active-high.
- `a`  in  WIDTH  data input.
- `y`  out  WIDTH  combinational inverse of `a`.
- `y_q`  out  WIDTH  registered inverse of `a`.
- `rise`  out  WIDTH  per-bit pulse, input bit went 0→1.
- `fall`  out  WIDTH  per-bit pulse, input bit went 1→0.
- `tcount`  out  COUNT_W  saturating count of cycles with any input change.
- `clr`  in  1  synchronous clear of `tcount`; tie to 0 if unused.

## Operation
- `y = ~a`, bit-wise and purely combinational. It does not depend on `clk`, `rst` or any state. It must stay correct when `clk`, `rst` and `clr` are left unconnected; the clocked outputs are don't-care in that case.
- Internal register `a_d` holds `a` sampled at the previous rising edge.
- `y_q` is registered `~a`, updated every rising edge.
- Edge pulses, per bit:
  - `rise[i] = a_d[i] & ~a_prev[i]`
  - `fall[i] = ~a_d[i] & a_prev[i]`
  - `a_prev` is `a_d` delayed one more cycle.
  - Both pulses are registered, so each is high for exactly one cycle.
  - `rise` and `fall` are never both high on the same bit.
- `tcount` increments by 1 on each rising edge where `a != a_d`, i.e. any bit differs.
  - It saturates at `2^COUNT_W − 1` and never wraps.
  - Unsigned arithmetic; the increment is computed at COUNT_W+1 bits and saturation is applied before writeback.
- `clr` = 1 at a rising edge sets `tcount` to 0.
  - `clr` has priority over an increment in the same cycle.
  - `clr` does not affect `y_q`, `rise` or `fall`.
- Reset (asynchronous, `rst` = 1) puts every register in a known state immediately, without a clock:

  | Register | Reset value |
  |---|---|
  | `a_d`, `a_prev` | all 0 |
  | `y_q` | all 1 (inverse of the idle input 0) |
  | `rise`, `fall` | 0 |
  | `tcount` | 0 |

- While `rst` is high: registers hold their reset values; `y` continues to follow `~a`.
- Reset deasserted mid-activity: the first edge after release samples `a` fresh. A change from the reset value 0 to the current `a` counts as a transition on that edge.
- No state machine; the block is a straight register pipeline.

## Timing
- `y`: zero-cycle latency, combinational delay only. A change of `a` at any time is reflected on `y` in the same delta or time step.
- `y_q`: 1-cycle latency. It reflects the `~a` sampled at the most recent rising edge.
- `tcount`: updated at the first rising edge after `a` changes (`a` vs `a_d` compare).
- `rise`/`fall`: asserted at the second rising edge after `a` changes, high for one cycle.
- Inputs must meet setup and hold time to `clk` for the clocked outputs. `y` has no timing requirement.

## Test plan
- Gate-only bench: `clk` toggles every 5 ns (period 10 ns); `a` = 0 at t=0; `a` = 1 at t=10 ns; finish at t=20 ns.
  - Required: `y` = 1 over 0–10 ns and `y` = 0 from 10 ns.
  - Each change of `a` or `y` is printed with its time.
- Reset: assert `rst` with no clock running.
  - Required: `y_q` = all 1, `rise` = `fall` = 0, `tcount` = 0 immediately.
  - `y` still tracks `~a` while `rst` is high.
- Registered path, WIDTH=4: drive `a` = 4'b1010, then 4'b0101, on consecutive cycles.
  - Required: `y_q` = 4'b0101, then 4'b1010, each one cycle after the input change.
  - `tcount` increments by 1 per change.
- Edges: `a` steps 0→1 and holds for 5 cycles, then 1→0.
  - Required: `rise` high for exactly 1 cycle, 2 edges after the 0→1 step.
  - `fall` likewise after the 1→0 step; never both high together.
- Saturation, COUNT_W=3: toggle `a` every cycle for 10 cycles.
  - Required: `tcount` reaches 7 and holds at 7 with no wrap.
  - Then `clr` = 1 for one cycle while `a` is still toggling: `tcount` = 0 on that edge, since clear wins over the increment.
- Reset mid-activity: assert `rst` while `a` toggles, release with `a` = 1.
  - Required: everything is cleared at once during reset.
  - The first edge after release gives `tcount` = 1 and `y_q` = 0.
